// File: rtl/seq_pkg.sv
// seq_pkg: shared types and helpers for call_stack_sequencer.
//   next_src_t  - which source feeds the next program-memory address
//   jmp_target  - expands a jump field into a full PM address
package seq_pkg;

  typedef enum logic [2:0] {
    SRC_RESET, SRC_HOLD, SRC_RET, SRC_RET_UF,
    SRC_CALL, SRC_JMP, SRC_JNZ, SRC_INC
  } next_src_t;

  localparam int MAX_ADDR_W = 32;

  // The jump field lands in the upper bits of the address; low bits are zero.
  function automatic logic [MAX_ADDR_W-1:0] jmp_target(
    input logic [MAX_ADDR_W-1:0] jaddr,
    input int                    pm_w,
    input int                    j_w
  );
    return jaddr << (pm_w - j_w);
  endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with a pointer register.
//   i_push/i_pop  - one operation per cycle (caller keeps them exclusive)
//   i_din         - value to push
//   o_top         - most recently pushed entry (undefined-but-zero when empty)
//   o_full/o_empty- occupancy flags, derived from the registered pointer
//   o_overflow    - push attempted while full (push dropped)
//   o_underflow   - pop attempted while empty (pointer unchanged)
module return_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sync_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_overflow,
  output logic         o_underflow
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_ptr;
  logic [W-1:0]  r_mem [DEPTH];

  assign o_full      = (r_ptr == PW'(DEPTH));
  assign o_empty     = (r_ptr == '0);
  assign o_overflow  = i_push & o_full;
  assign o_underflow = i_pop & o_empty;

  // Pointer counts occupied entries, so the top lives at ptr-1.
  always_comb begin
    o_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_ptr == PW'(i + 1)) o_top = r_mem[i];
  end

  always_ff @(posedge clk) begin
    if (sync_reset)                r_ptr <= '0;
    else if (i_push && !o_full)    r_ptr <= r_ptr + 1'b1;
    else if (i_pop  && !o_empty)   r_ptr <= r_ptr - 1'b1;
  end

  // Entries carry no reset; an overflowing push leaves them untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (i_push && !o_full && r_ptr == PW'(i)) r_mem[i] <= i_din;
  end

endmodule

// File: rtl/call_stack_sequencer.sv
// call_stack_sequencer: program sequencer with a hardware return stack.
//   clk, sync_reset      - clock, synchronous active-high reset
//   i_hold               - freeze pc and all stack/error activity
//   i_jmp, i_jmp_nz      - unconditional / conditional (on !i_dont_jmp) jump
//   i_call, i_ret        - subroutine call (push pc+1) / return (pop)
//   i_jmp_addr           - jump/call target field (upper address bits)
//   o_pm_addr            - combinational next address to program memory
//   o_pc                 - registered current address
//   o_stack_full/_empty  - stack occupancy
//   o_stack_err          - sticky overflow/underflow flag, cleared by reset
module call_stack_sequencer
  import seq_pkg::*;
#(
  parameter int PM_ADDR_W   = 8,
  parameter int JMP_ADDR_W  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  i_hold,
  input  logic                  i_jmp,
  input  logic                  i_jmp_nz,
  input  logic                  i_dont_jmp,
  input  logic                  i_call,
  input  logic                  i_ret,
  input  logic [JMP_ADDR_W-1:0] i_jmp_addr,
  output logic [PM_ADDR_W-1:0]  o_pm_addr,
  output logic [PM_ADDR_W-1:0]  o_pc,
  output logic                  o_stack_full,
  output logic                  o_stack_empty,
  output logic                  o_stack_err
);
  logic [PM_ADDR_W-1:0] r_pc;
  logic                 r_err;
  next_src_t            w_src;
  logic [PM_ADDR_W-1:0] w_target, w_pc_inc, w_top;
  logic                 w_push, w_pop, w_full, w_empty, w_ovf, w_unf;

  assign w_target = PM_ADDR_W'(jmp_target(MAX_ADDR_W'(i_jmp_addr), PM_ADDR_W, JMP_ADDR_W));
  assign w_pc_inc = r_pc + PM_ADDR_W'(1);  // wraps modulo 2^PM_ADDR_W

  always_comb begin
    w_src = SRC_INC;
    if      (sync_reset)             w_src = SRC_RESET;
    else if (i_hold)                 w_src = SRC_HOLD;
    else if (i_ret && !w_empty)      w_src = SRC_RET;
    else if (i_ret)                  w_src = SRC_RET_UF;
    else if (i_call)                 w_src = SRC_CALL;
    else if (i_jmp)                  w_src = SRC_JMP;
    else if (i_jmp_nz && !i_dont_jmp) w_src = SRC_JNZ;
  end

  always_comb begin
    o_pm_addr = w_pc_inc;
    case (w_src)
      SRC_RESET:                 o_pm_addr = '0;
      SRC_HOLD:                  o_pm_addr = r_pc;
      SRC_RET:                   o_pm_addr = w_top;
      SRC_CALL, SRC_JMP, SRC_JNZ: o_pm_addr = w_target;
      default:                   o_pm_addr = w_pc_inc;
    endcase
  end

  // Stack ops derive from the winning source, so hold/reset and
  // lower-priority losers never touch the stack.
  assign w_push = (w_src == SRC_CALL);
  assign w_pop  = (w_src == SRC_RET) || (w_src == SRC_RET_UF);

  return_stack #(.W(PM_ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_din       (w_pc_inc),
    .o_top       (w_top),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_pc  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= o_pm_addr;
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  assign o_pc          = r_pc;
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_stack_err   = r_err;

endmodule

// File: tb/tb_call_stack_sequencer.sv
module tb_call_stack_sequencer;
  logic       clk = 1'b0;
  logic       sync_reset = 1'b1;
  logic       hold = 0, jmp = 0, jmp_nz = 0, dont_jmp = 0, call = 0, ret = 0;
  logic [3:0] jmp_addr = '0;
  logic [7:0] pm_addr, pc;
  logic       full, empty, err;

  int total = 0;
  int bad   = 0;

  // Reference model: pc as an integer, the stack as a queue.
  int unsigned m_pc = 0;
  logic [7:0]  m_stk[$];
  bit          m_err = 0;
  logic [7:0]  exp_pm;
  int unsigned p_pc;
  bit          p_full, p_empty, p_err;

  call_stack_sequencer #(.PM_ADDR_W(8), .JMP_ADDR_W(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .sync_reset(sync_reset), .i_hold(hold), .i_jmp(jmp),
    .i_jmp_nz(jmp_nz), .i_dont_jmp(dont_jmp), .i_call(call), .i_ret(ret),
    .i_jmp_addr(jmp_addr), .o_pm_addr(pm_addr), .o_pc(pc),
    .o_stack_full(full), .o_stack_empty(empty), .o_stack_err(err)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    int unsigned tgt;
    int unsigned inc;
    tgt = int'(jmp_addr) * 16;
    inc = (m_pc + 1) % 256;
    if (sync_reset) begin
      exp_pm = 0; m_stk.delete(); m_err = 0;
    end else if (hold) begin
      exp_pm = 8'(m_pc);
    end else if (ret) begin
      if (m_stk.size() > 0) exp_pm = m_stk.pop_back();
      else begin exp_pm = 8'(inc); m_err = 1; end
    end else if (call) begin
      exp_pm = 8'(tgt);
      if (m_stk.size() < 4) m_stk.push_back(8'(inc));
      else m_err = 1;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      exp_pm = 8'(tgt);
    end else begin
      exp_pm = 8'(inc);
    end
    m_pc = exp_pm;
  endtask

  // Apply one cycle of controls after the falling edge, snapshot the
  // model's pre-edge state, then advance the model.
  task automatic drv(input bit r, input bit h, input bit j, input bit jz,
                     input bit dz, input bit c, input bit rt, input logic [3:0] a);
    @(negedge clk);
    sync_reset = r; hold = h; jmp = j; jmp_nz = jz; dont_jmp = dz;
    call = c; ret = rt; jmp_addr = a;
    #1;
    p_pc = m_pc; p_full = (m_stk.size() == 4); p_empty = (m_stk.size() == 0); p_err = m_err;
    model_eval();
  endtask

  task automatic idle(); drv(0,0,0,0,0,0,0,4'h0); endtask

  task automatic test_reset();
    drv(1,0,0,0,0,0,0,4'h0);
    total++; if (pm_addr !== 8'h00) begin bad++; $display("FAIL reset_pm got=%h want=00", pm_addr); end
    idle();
    total++; if (pc !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_state pc=%h empty=%b full=%b err=%b want 00/1/0/0", pc, empty, full, err); end
    total++; if (pm_addr !== 8'h01) begin bad++; $display("FAIL inc1 got=%h want=01", pm_addr); end
    idle();
    total++; if (pm_addr !== 8'h02) begin bad++; $display("FAIL inc2 got=%h want=02", pm_addr); end
    drv(0,0,1,0,0,0,0,4'hF);
    for (int i = 0; i < 15; i++) idle();
    idle();
    total++; if (pc !== 8'hFF || pm_addr !== 8'h00) begin
      bad++; $display("FAIL wrap pc=%h pm=%h want FF/00", pc, pm_addr); end
  endtask

  task automatic test_jumps_hold();
    drv(0,0,1,0,0,0,0,4'hA);
    total++; if (pm_addr !== 8'hA0) begin bad++; $display("FAIL jmp got=%h want=A0", pm_addr); end
    idle();
    total++; if (pm_addr !== 8'hA1) begin bad++; $display("FAIL jmp_inc got=%h want=A1", pm_addr); end
    drv(0,0,0,1,1,0,0,4'h3);
    total++; if (pm_addr !== 8'hA2) begin bad++; $display("FAIL jnz_not_taken got=%h want=A2", pm_addr); end
    drv(0,0,0,1,0,0,0,4'h1);
    total++; if (pm_addr !== 8'h10) begin bad++; $display("FAIL jnz_taken got=%h want=10", pm_addr); end
    for (int i = 0; i < 3; i++) begin
      drv(0,1,1,0,0,0,0,4'h7);
      total++; if (pm_addr !== 8'h10 || pc !== 8'h10) begin
        bad++; $display("FAIL hold pm=%h pc=%h want 10/10", pm_addr, pc); end
    end
  endtask

  task automatic test_single_call();
    idle(); idle(); idle();
    drv(0,0,0,0,0,1,0,4'h5);
    total++; if (pc !== 8'h13 || pm_addr !== 8'h50) begin
      bad++; $display("FAIL call pc=%h pm=%h want 13/50", pc, pm_addr); end
    idle();
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL call_empty got=%b want=0", empty); end
    drv(0,0,0,0,0,0,1,4'h0);
    total++; if (pm_addr !== 8'h14) begin bad++; $display("FAIL ret got=%h want=14", pm_addr); end
    idle();
    total++; if (empty !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL ret_empty empty=%b err=%b want 1/0", empty, err); end
  endtask

  task automatic test_nested();
    logic [7:0] want [4];
    want = '{8'h31, 8'h21, 8'h11, 8'h01};
    drv(1,0,0,0,0,0,0,4'h0);
    for (int i = 1; i <= 4; i++) begin
      drv(0,0,(i == 2),0,0,1,0,4'(i));  // call+jmp behaves as call
      total++; if (pm_addr !== 8'(i * 16)) begin
        bad++; $display("FAIL nest_call%0d got=%h want=%h", i, pm_addr, 8'(i * 16)); end
    end
    drv(0,0,0,0,0,1,0,4'h5);
    total++; if (full !== 1'b1 || err !== 1'b0 || pm_addr !== 8'h50) begin
      bad++; $display("FAIL overflow_call full=%b err=%b pm=%h want 1/0/50", full, err, pm_addr); end
    drv(0,1,0,0,0,0,1,4'h0);  // held ret must not pop
    total++; if (err !== 1'b1 || full !== 1'b1 || pm_addr !== 8'h50) begin
      bad++; $display("FAIL overflow_err err=%b full=%b pm=%h want 1/1/50", err, full, pm_addr); end
    for (int i = 0; i < 4; i++) begin
      drv(0,0,0,0,0,(i == 0),1,4'h9);  // ret+call behaves as ret
      total++; if (pm_addr !== want[i]) begin
        bad++; $display("FAIL nest_ret%0d got=%h want=%h", i, pm_addr, want[i]); end
    end
    idle();
    total++; if (empty !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL nest_end empty=%b err=%b want 1/1", empty, err); end
  endtask

  task automatic test_underflow();
    drv(1,0,0,0,0,0,0,4'h0);
    drv(0,0,1,0,0,0,0,4'h4);
    idle();
    drv(0,0,0,0,0,0,1,4'h0);
    total++; if (pc !== 8'h41 || pm_addr !== 8'h42) begin
      bad++; $display("FAIL underflow pc=%h pm=%h want 41/42", pc, pm_addr); end
    for (int i = 0; i < 3; i++) idle();
    total++; if (err !== 1'b1 || empty !== 1'b1) begin
      bad++; $display("FAIL underflow_sticky err=%b empty=%b want 1/1", err, empty); end
    drv(1,0,0,0,0,0,0,4'h0);
    idle();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL underflow_clear got=%b want=0", err); end
  endtask

  task automatic test_reset_mid();
    drv(0,0,0,0,0,1,0,4'h2);
    drv(0,0,0,0,0,1,0,4'h3);
    drv(1,0,0,0,0,0,1,4'h0);
    total++; if (pm_addr !== 8'h00) begin bad++; $display("FAIL mid_reset_pm got=%h want=00", pm_addr); end
    idle();
    total++; if (empty !== 1'b1 || err !== 1'b0 || pm_addr !== 8'h01) begin
      bad++; $display("FAIL mid_reset_state empty=%b err=%b pm=%h want 1/0/01", empty, err, pm_addr); end
    drv(0,0,0,0,0,0,1,4'h0);
    total++; if (pm_addr !== 8'h02) begin bad++; $display("FAIL mid_reset_ret got=%h want=02", pm_addr); end
    idle();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_reset_uf got=%b want=1", err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          4'($urandom));
      total++; if (pm_addr !== exp_pm) begin
        bad++; $display("FAIL rnd_pm cyc=%0d got=%h want=%h", i, pm_addr, exp_pm); end
      total++; if (pc !== 8'(p_pc)) begin
        bad++; $display("FAIL rnd_pc cyc=%0d got=%h want=%h", i, pc, 8'(p_pc)); end
      total++; if (full !== p_full || empty !== p_empty || err !== p_err) begin
        bad++; $display("FAIL rnd_flags cyc=%0d full=%b empty=%b err=%b want %b/%b/%b",
                        i, full, empty, err, p_full, p_empty, p_err); end
    end
  endtask

  initial begin
    test_reset();
    test_jumps_hold();
    test_single_call();
    test_nested();
    test_underflow();
    test_reset_mid();
    test_random();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
